// File: rtl/time_disp_pkg.sv
// Shared field widths, the display time record and hour arithmetic helpers
// for the display-source selector.
package time_disp_pkg;

    localparam int MSEC_W        = 7;
    localparam int SEC_W         = 6;
    localparam int MIN_W         = 6;
    localparam int HOUR_W        = 5;
    localparam int HOURS_PER_DAY = 24;

    typedef struct packed {
        logic [MSEC_W-1:0] msec;
        logic [SEC_W-1:0]  sec;
        logic [MIN_W-1:0]  min;
        logic [HOUR_W-1:0] hour;
    } time_t;

    // Both operands are below 24, so one conditional subtract is a full mod-24.
    function automatic logic [HOUR_W-1:0] hour_wrap_add(input logic [HOUR_W-1:0] h,
                                                        input logic [HOUR_W-1:0] off);
        logic [HOUR_W:0] sum;
        sum = {1'b0, h} + {1'b0, off};
        if (sum >= (HOUR_W+1)'(HOURS_PER_DAY)) begin
            sum = sum - (HOUR_W+1)'(HOURS_PER_DAY);
        end
        return sum[HOUR_W-1:0];
    endfunction

    // Returns {pm, hour} with hour in 1..12.
    function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] h);
        logic            pm;
        logic [HOUR_W-1:0] hr;
        pm = (h >= HOUR_W'(12));
        hr = pm ? h - HOUR_W'(12) : h;
        if (hr == '0) begin
            hr = HOUR_W'(12);
        end
        return {pm, hr};
    endfunction

endpackage

// File: rtl/hour_fmt.sv
// Combinational hour formatter: sanitises out-of-range hours, applies the
// channel hour offset with mod-24 wrap, then optionally converts to 12-hour.
module hour_fmt
    import time_disp_pkg::*;
#(
    parameter int HOUR_OFFSET = 12
) (
    input  logic [HOUR_W-1:0] i_hour,
    input  logic              i_off_en,
    input  logic              i_fmt_12h,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_pm
);

    logic [HOUR_W-1:0] h_clean;
    logic [HOUR_W-1:0] h_off;
    logic [HOUR_W:0]   h12;

    always_comb begin
        h_clean = (i_hour > HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : i_hour;
        h_off   = i_off_en ? hour_wrap_add(h_clean, HOUR_W'(HOUR_OFFSET)) : h_clean;
        h12     = to_12h(h_off);
        o_hour  = h_off;
        o_pm    = 1'b0;
        if (i_fmt_12h) begin
            o_hour = h12[HOUR_W-1:0];
            o_pm   = h12[HOUR_W];
        end
    end

endmodule

// File: rtl/time_disp_sel.sv
// Registered display-source selector: picks one of NUM_CH time channels,
// formats its hour, and blanks the display for BLANK_CYC cycles per channel change.
module time_disp_sel
    import time_disp_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int OFFSET_CH   = 1,
    parameter int HOUR_OFFSET = 12,
    parameter int BLANK_CYC   = 4,
    parameter int CH_W        = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_mode_next,
    input  logic                     i_mode_load,
    input  logic [CH_W-1:0]          i_mode_ch,
    input  logic                     i_fmt_12h,
    input  logic [NUM_CH*MSEC_W-1:0] i_msec,
    input  logic [NUM_CH*SEC_W-1:0]  i_sec,
    input  logic [NUM_CH*MIN_W-1:0]  i_min,
    input  logic [NUM_CH*HOUR_W-1:0] i_hour,
    output logic [MSEC_W-1:0]        o_msec,
    output logic [SEC_W-1:0]         o_sec,
    output logic [MIN_W-1:0]         o_min,
    output logic [HOUR_W-1:0]        o_hour,
    output logic                     o_pm,
    output logic [CH_W-1:0]          o_ch,
    output logic                     o_switch,
    output logic                     o_blank
);

    localparam int CNT_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    logic [CH_W-1:0]  ch_q, ch_d;
    time_t            tm_q, tm_d;
    logic             pm_q, pm_d;
    logic             switch_q, switch_d;
    logic             blank_q, blank_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    time_t             sel;
    logic              off_en;
    logic [HOUR_W-1:0] fmt_hour;
    logic              fmt_pm;
    logic              load_ok;
    logic              change;

    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                sel.msec = i_msec[k*MSEC_W +: MSEC_W];
                sel.sec  = i_sec[k*SEC_W +: SEC_W];
                sel.min  = i_min[k*MIN_W +: MIN_W];
                sel.hour = i_hour[k*HOUR_W +: HOUR_W];
            end
        end
        off_en = (ch_q == CH_W'(OFFSET_CH));
    end

    hour_fmt #(
        .HOUR_OFFSET (HOUR_OFFSET)
    ) u_hour_fmt (
        .i_hour    (sel.hour),
        .i_off_en  (off_en),
        .i_fmt_12h (i_fmt_12h),
        .o_hour    (fmt_hour),
        .o_pm      (fmt_pm)
    );

    always_comb begin
        load_ok = i_mode_load && ({1'b0, i_mode_ch} < (CH_W+1)'(NUM_CH));
        ch_d    = ch_q;
        // An out-of-range load swallows a coincident step as well.
        if (i_mode_load) begin
            if (load_ok) begin
                ch_d = i_mode_ch;
            end
        end else if (i_mode_next) begin
            ch_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
        end
        change   = (ch_d != ch_q);
        switch_d = change;

        cnt_d = cnt_q;
        if (change) begin
            cnt_d = CNT_W'(BLANK_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        blank_d = (cnt_d != '0);

        tm_d      = sel;
        tm_d.hour = fmt_hour;
        pm_d      = fmt_pm;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q     <= '0;
            tm_q     <= '0;
            pm_q     <= 1'b0;
            switch_q <= 1'b0;
            blank_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ch_q     <= ch_d;
            tm_q     <= tm_d;
            pm_q     <= pm_d;
            switch_q <= switch_d;
            blank_q  <= blank_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_msec   = tm_q.msec;
    assign o_sec    = tm_q.sec;
    assign o_min    = tm_q.min;
    assign o_hour   = tm_q.hour;
    assign o_pm     = pm_q;
    assign o_ch     = ch_q;
    assign o_switch = switch_q;
    assign o_blank  = blank_q;

endmodule

// File: doc/time_disp_sel.md
# time_disp_sel

Registered, parametrised display-source selector for the stopwatch/watch system. It chooses one of NUM_CH time channels (stopwatch, watch, alarm, …) for the FND/display path. It applies a per-design hour offset with correct modulo-24 wrap and an optional 12-hour conversion. Channels are selected by step pulses or direct load, and the display blanks for a short window after each channel change.

## Interface
Parameters:
- NUM_CH, 3, number of time channels (2..8); channel 0 is the stopwatch.
- OFFSET_CH, 1, channel index that receives the hour offset.
- HOUR_OFFSET, 12, hours added to OFFSET_CH's hour (0..23).
- BLANK_CYC, 4, cycles o_blank is held after a channel change; 0 disables blanking.
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_mode_next  in  1  single-cycle pulse that advances to the next channel.
- i_mode_load  in  1  single-cycle pulse that loads i_mode_ch.
- i_mode_ch  in  CH_W  direct channel index.
- i_fmt_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
- i_msec  in  NUM_CH*7  packed msec fields; channel k occupies [7k+6:7k].
- i_sec  in  NUM_CH*6  packed seconds fields.
- i_min  in  NUM_CH*6  packed minutes fields.
- i_hour  in  NUM_CH*5  packed hours fields.
- o_msec  out  7  selected msec.
- o_sec  out  6  selected seconds.
- o_min  out  6  selected minutes.
- o_hour  out  5  selected and formatted hour.
- o_pm  out  1  PM flag; valid only in 12-hour mode, otherwise 0.
- o_ch  out  CH_W  current channel.
- o_switch  out  1  one-cycle pulse after each channel change.
- o_blank  out  1  display blank request.

## Operation
- Channel register ch_q:
  - On i_mode_load with i_mode_ch < NUM_CH: ch_q ← i_mode_ch.
  - Else on i_mode_next: ch_q ← ch_q+1, wrapping NUM_CH-1 → 0.
  - i_mode_load has priority over i_mode_next.
  - A load with i_mode_ch ≥ NUM_CH is ignored entirely; i_mode_next in the same cycle is also ignored.
  - A load or step that leaves ch_q unchanged is not a change.
- Change detect: when ch_q changes, o_switch pulses and the blank counter loads BLANK_CYC.
  - o_blank = (counter ≠ 0).
  - A new change during blanking reloads the counter.
- Hour path, applied to the hour of the selected channel:
  - h_in > 23 is treated as 0.
  - If ch_q == OFFSET_CH: h = (h_in + HOUR_OFFSET) mod 24, computed 6-bit wide. For example, 15 + 12 → 3, not 27.
  - 24-hour mode: o_hour = h, o_pm = 0.
  - 12-hour mode: h = 0 → 12/AM; h = 1..11 → h/AM; h = 12 → 12/PM; h = 13..23 → h-12/PM.
- msec, sec and min pass through unmodified from the selected channel.

## Timing
- Reset values: ch_q = 0, o_ch = 0, all time outputs 0, o_pm = 0, o_switch = 0, o_blank = 0, blank counter 0.
- Reset mid-blank clears blanking immediately.
- All outputs are registered.
- Data latency: input field to output is 1 cycle.
- Channel latency:
  - Pulse sampled at edge t → o_ch and o_switch at t+1.
  - o_blank asserts at t+1 and stays high for exactly BLANK_CYC cycles.
  - New channel's data appears at t+2.
- Format latency: an i_fmt_12h change affects o_hour/o_pm 1 cycle later and does not trigger blanking.
- Back-to-back i_mode_next pulses each advance one channel; there is no lockout.

## Structure
- Package time_disp_pkg holds:
  - Field widths MSEC_W = 7, SEC_W = 6, MIN_W = 6, HOUR_W = 5.
  - HOURS_PER_DAY = 24.
  - Functions hour_wrap_add(h, off) and to_12h(h) → {pm, hour}.
- Sub-module hour_fmt: combinational offset/wrap/12-hour conversion, instantiated once on the selected channel's hour. Its output feeds the o_hour/o_pm registers.

## Test plan
- Reset, then apply channel 0 fields {msec 55, sec 30, min 12, hour 7} → after 1 cycle outputs are 55/30/12/7; o_ch = 0; o_blank = 0.
- NUM_CH = 3: pulse i_mode_next three times, 4 cycles apart → o_ch goes 1, 2, 0. Each change gives o_switch high for 1 cycle and o_blank high for exactly 4 cycles. New data appears 2 cycles after each pulse.
- OFFSET_CH = 1, channel 1 hour = 15:
  - 24-hour mode → o_hour = 3, o_pm = 0.
  - 12-hour mode → o_hour = 3, o_pm = 0.
  - Hour = 0 in 12-hour mode → o_hour = 12, o_pm = 1.
- Channel 0 hour = 0, 12, 23 in 12-hour mode → 12/AM, 12/PM, 11/PM. Hour = 25 → treated as 0 → 12/AM.
- i_mode_load with ch = 2 together with i_mode_next while on ch 0 → o_ch = 2. A subsequent i_mode_ch = 3 load → ignored, no o_switch.
- Assert reset two cycles into a blank window → o_blank and o_ch drop to 0 immediately, with no residual pulse after release.
